// File: rtl/arbitro_memoria_datos_pkg.sv
// arbitro_memoria_datos_pkg: FSM encoding and memory read-latency modes shared by the arbiter and its bench
package arbitro_memoria_datos_pkg;
    localparam int LOW_LATENCY      = 1;
    localparam int HIGH_PERFORMANCE = 2;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        SEND     = 3'd3,
        DONE     = 3'd4
    } estado_t;
endpackage

// File: rtl/arbitro_memoria_datos.sv
// arbitro_memoria_datos: shares the data memory port between the CPU (absolute priority) and a debug dump sequencer
module arbitro_memoria_datos
    import arbitro_memoria_datos_pkg::*;
#(
    parameter int RAM_WIDTH    = 16,
    parameter int RAM_DEPTH    = 1024,
    parameter int ADDR_WIDTH   = 11,
    parameter int READ_LATENCY = LOW_LATENCY
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cpu_active,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [RAM_WIDTH-1:0]  i_cpu_data,
    input  logic                  i_cpu_wea,
    input  logic                  i_cpu_regcea,
    output logic [RAM_WIDTH-1:0]  o_cpu_data,
    input  logic                  i_dump_start,
    input  logic [ADDR_WIDTH-1:0] i_dump_len,
    output logic [ADDR_WIDTH-1:0] o_dump_addr,
    output logic [RAM_WIDTH-1:0]  o_dump_data,
    output logic                  o_dump_valid,
    input  logic                  i_dump_ready,
    output logic                  o_dump_busy,
    output logic                  o_dump_done,
    output logic                  o_dump_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [RAM_WIDTH-1:0]  o_mem_data,
    output logic                  o_mem_wea,
    output logic                  o_mem_regcea,
    input  logic [RAM_WIDTH-1:0]  i_mem_data
);
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(RAM_DEPTH);
    estado_t               estado;
    logic [ADDR_WIDTH-1:0] addr_cnt, len, len_lim;
    logic [1:0]            espera;
    logic                  leyendo;
    always_comb begin
        leyendo      = estado == RD_ISSUE || estado == RD_WAIT;
        len_lim      = i_dump_len > DEPTH ? DEPTH : i_dump_len;
        o_cpu_data   = i_mem_data;
        o_mem_addr   = i_cpu_active ? i_cpu_addr : (leyendo ? addr_cnt : '0);
        o_mem_data   = i_cpu_active ? i_cpu_data : '0;
        o_mem_wea    = i_cpu_active & i_cpu_wea;
        o_mem_regcea = i_cpu_active ? i_cpu_regcea : leyendo;
    end
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            estado       <= IDLE;
            addr_cnt     <= '0;
            len          <= '0;
            espera       <= '0;
            o_dump_addr  <= '0;
            o_dump_data  <= '0;
            o_dump_valid <= 1'b0;
            o_dump_busy  <= 1'b0;
            o_dump_done  <= 1'b0;
            o_dump_err   <= 1'b0;
        end else begin
            o_dump_done <= 1'b0;
            o_dump_err  <= 1'b0;
            // CPU reclaiming the memory mid-dump aborts it without a done pulse
            if (i_cpu_active && estado != IDLE) begin
                estado       <= IDLE;
                o_dump_valid <= 1'b0;
                o_dump_busy  <= 1'b0;
                o_dump_err   <= 1'b1;
            end else begin
                case (estado)
                    IDLE: if (i_dump_start && !i_cpu_active) begin
                        len         <= len_lim;
                        addr_cnt    <= '0;
                        o_dump_busy <= len_lim != '0;
                        o_dump_done <= len_lim == '0;
                        estado      <= len_lim == '0 ? DONE : RD_ISSUE;
                    end
                    RD_ISSUE: begin
                        espera <= 2'(READ_LATENCY - 1);
                        estado <= RD_WAIT;
                    end
                    RD_WAIT: if (espera == 2'd0) begin
                        o_dump_data  <= i_mem_data;
                        o_dump_addr  <= addr_cnt;
                        o_dump_valid <= 1'b1;
                        estado       <= SEND;
                    end else begin
                        espera <= espera - 2'd1;
                    end
                    SEND: if (i_dump_ready) begin
                        o_dump_valid <= 1'b0;
                        addr_cnt     <= addr_cnt + 1'b1;
                        if (ADDR_WIDTH'(addr_cnt + 1'b1) == len) begin
                            estado      <= DONE;
                            o_dump_done <= 1'b1;
                            o_dump_busy <= 1'b0;
                        end else begin
                            estado <= RD_ISSUE;
                        end
                    end
                    DONE:    estado <= IDLE;
                    default: estado <= IDLE;
                endcase
            end
        end
    end
endmodule
